// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the MIPS
// pipeline (port 0) and the AES engine (port 1). Round-robin arbitration,
// locked bursts bounded by MAX_BURST, and address-range error reporting.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 384,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m0_err,
   output logic              m1_err,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

   localparam int                BCNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [BCNT_W-1:0] BCNT_MAX    = BCNT_W'(MAX_BURST);
   localparam logic [BCNT_W-1:0] BCNT_ONE    = BCNT_W'(1);
   localparam logic [ADDR_W-1:0] WORDS_LIMIT = ADDR_W'(MEM_WORDS);
   // With MAX_BURST=1 a lock can never extend past its own grant.
   localparam bit                LOCK_EN     = (MAX_BURST > 1);

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [BCNT_W-1:0]   bcnt_inc;

   logic                m0_rvalid_q, m0_rvalid_d;
   logic                m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
   logic                m0_err_q, m0_err_d;
   logic                m1_err_q, m1_err_d;

   logic                gnt0, gnt1, any_gnt;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_err;
   logic [DATA_W-1:0]   resp_data;

   // Misaligned or beyond the implemented words: granted but never issued.
   function automatic logic addr_err(input logic [ADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= WORDS_LIMIT);
   endfunction

   assign bcnt_inc = bcnt_q + BCNT_ONE;

   // Arbitration: owner continues its burst, otherwise round-robin over requesters.
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      state_d = state_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      if (state_q == S_OWN0 && m0_req) begin
         gnt0   = 1'b1;
         last_d = 1'b0;
         bcnt_d = bcnt_inc;
         if (!m0_lock || bcnt_inc == BCNT_MAX) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
         end
      end else if (state_q == S_OWN1 && m1_req) begin
         gnt1   = 1'b1;
         last_d = 1'b1;
         bcnt_d = bcnt_inc;
         if (!m1_lock || bcnt_inc == BCNT_MAX) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
         end
      end else begin
         // Idle, or the owner dropped its request: ownership ends this cycle.
         state_d = S_IDLE;
         bcnt_d  = '0;
         if (m0_req && (!m1_req || last_q)) begin
            gnt0   = 1'b1;
            last_d = 1'b0;
            if (m0_lock && LOCK_EN) begin
               state_d = S_OWN0;
               bcnt_d  = BCNT_ONE;
            end
         end else if (m1_req) begin
            gnt1   = 1'b1;
            last_d = 1'b1;
            if (m1_lock && LOCK_EN) begin
               state_d = S_OWN1;
               bcnt_d  = BCNT_ONE;
            end
         end
      end
      if (reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   // Memory drive from the granted port; blanked when idle or on error.
   always_comb begin
      any_gnt   = gnt0 | gnt1;
      sel_we    = gnt0 ? m0_we    : m1_we;
      sel_addr  = gnt0 ? m0_addr  : m1_addr;
      sel_wdata = gnt0 ? m0_wdata : m1_wdata;
      sel_err   = addr_err(sel_addr);
      mem_we    = any_gnt & sel_we & ~sel_err;
      mem_re    = any_gnt & ~sel_we & ~sel_err;
      mem_addr  = (any_gnt && !sel_err) ? sel_addr  : '0;
      mem_wdata = (any_gnt && !sel_err) ? sel_wdata : '0;
      resp_data = (!sel_err && !sel_we) ? mem_rdata : '0;
   end

   // Response capture: granted port loads result, the other holds its last value.
   always_comb begin
      m0_rvalid_d = gnt0;
      m1_rvalid_d = gnt1;
      m0_rdata_d  = gnt0 ? resp_data : m0_rdata_q;
      m1_rdata_d  = gnt1 ? resp_data : m1_rdata_q;
      m0_err_d    = gnt0 ? sel_err   : m0_err_q;
      m1_err_d    = gnt1 ? sel_err   : m1_err_q;
   end

   // State and response registers; reset drops any ownership and pending rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         bcnt_q      <= '0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         bcnt_q      <= bcnt_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         m0_err_q    <= m0_err_d;
         m1_err_q    <= m1_err_d;
      end
   end

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, reference model with per-cycle
// compare, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MEM_WORDS = 384;
   localparam int MAX_BURST = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we, mem_re;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [0:MEM_WORDS-1];
   logic [31:0] ref_mem [0:MEM_WORDS-1];

   int total = 0;
   int bad   = 0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write at the end of the cycle.
   assign mem_rdata = (mem_addr[31:11] == 21'd0 && mem_addr[10:2] < 9'd384) ? mem[mem_addr[10:2]] : 32'h0;
   always @(posedge clk) begin
      if (mem_we && mem_addr[31:11] == 21'd0 && mem_addr[10:2] < 9'd384)
         mem[mem_addr[10:2]] <= mem_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          own    = -1;   // port holding a lock, -1 when none
   int          last_m = 1;
   int          cnt    = 0;    // grants in the current locked run
   bit          mvalid = 0;
   logic        exp_rv [2];
   logic [31:0] exp_rd [2];
   logic        exp_e  [2];

   always @(negedge clk) begin
      int          g;
      logic [31:0] a, wd;
      logic        w, lk, er, ewe, ere;
      if (reset) begin
         chk("rst_gnt0", m0_gnt, 0);
         chk("rst_gnt1", m1_gnt, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_re", mem_re, 0);
         if (mvalid) begin
            chk("m_rv0", m0_rvalid, exp_rv[0]);
            chk("m_rv1", m1_rvalid, exp_rv[1]);
         end
         own = -1; last_m = 1; cnt = 0; mvalid = 1;
         for (int p = 0; p < 2; p++) begin
            exp_rv[p] = 0; exp_rd[p] = 0; exp_e[p] = 0;
         end
      end else if (mvalid) begin
         chk("m_rv0", m0_rvalid, exp_rv[0]);
         chk("m_rv1", m1_rvalid, exp_rv[1]);
         if (exp_rv[0]) begin chk("m_rd0", m0_rdata, exp_rd[0]); chk("m_err0", m0_err, exp_e[0]); end
         if (exp_rv[1]) begin chk("m_rd1", m1_rdata, exp_rd[1]); chk("m_err1", m1_err, exp_e[1]); end
         // Who wins this cycle
         g = -1;
         if (own == 0 && m0_req)         g = 0;
         else if (own == 1 && m1_req)    g = 1;
         else if (m0_req && m1_req)      g = 1 - last_m;
         else if (m0_req)                g = 0;
         else if (m1_req)                g = 1;
         chk("m_gnt0", m0_gnt, g == 0);
         chk("m_gnt1", m1_gnt, g == 1);
         a  = (g == 0) ? m0_addr  : m1_addr;
         wd = (g == 0) ? m0_wdata : m1_wdata;
         w  = (g == 0) ? m0_we    : m1_we;
         lk = (g == 0) ? m0_lock  : m1_lock;
         er = (g >= 0) && ((a % 4) != 0 || (a / 4) >= MEM_WORDS);
         ewe = (g >= 0) && w && !er;
         ere = (g >= 0) && !w && !er;
         chk("m_mem_we", mem_we, ewe);
         chk("m_mem_re", mem_re, ere);
         chk("m_mem_addr", mem_addr, (ewe || ere) ? a : 32'h0);
         chk("m_mem_wdata", mem_wdata, (ewe || ere) ? wd : 32'h0);
         for (int p = 0; p < 2; p++) begin
            exp_rv[p] = (g == p);
            if (g == p) begin
               exp_rd[p] = ere ? ref_mem[a / 4] : 32'h0;
               exp_e[p]  = er;
            end
         end
         if (ewe) ref_mem[a / 4] = wd;
         if (g >= 0) begin
            cnt    = (own == g) ? cnt + 1 : 1;
            own    = (lk && cnt < MAX_BURST) ? g : -1;
            last_m = g;
         end else begin
            own = -1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle_in();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      int n1;
      int pat [12];
      pat = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
      for (int i = 0; i < MEM_WORDS; i++) begin
         mem[i]     = 32'h1000 + 32'(i);
         ref_mem[i] = 32'h1000 + 32'(i);
      end
      mem[128] = 32'h63;
      ref_mem[128] = 32'h63;
      idle_in();
      reset = 1;
      nxt(); nxt();
      reset = 0;

      // Round-robin ties, port 0 first after reset
      m0_req = 1; m0_addr = 32'h4; m1_req = 1; m1_addr = 32'h8;
      for (int k = 0; k < 6; k++) begin
         smp();
         chk("rr_gnt0", m0_gnt, (k % 2) == 0);
         chk("rr_gnt1", m1_gnt, (k % 2) == 1);
         nxt();
      end
      idle_in();

      // Single read of the first S-box word
      m0_req = 1; m0_addr = 32'h200;
      smp();
      chk("rd_gnt", m0_gnt, 1);
      chk("rd_mem_re", mem_re, 1);
      chk("rd_mem_addr", mem_addr, 32'h200);
      nxt(); idle_in();
      smp();
      chk("rd_rvalid", m0_rvalid, 1);
      chk("rd_rdata", m0_rdata, 32'h63);
      chk("rd_err", m0_err, 0);
      nxt();

      // Locked burst from port 1 against a continuous port 0
      n1 = 0;
      for (int c = 0; c < 12; c++) begin
         if (c >= 1) begin m0_req = 1; m0_addr = 32'h10; end
         m1_lock = 1;
         m1_req  = (n1 < 10);
         m1_addr = 32'(32'h200 + 4 * n1);
         smp();
         chk("burst_gnt1", m1_gnt, pat[c] == 1);
         chk("burst_gnt0", m0_gnt, pat[c] == 0);
         if (c > 0) chk("burst_rv1", m1_rvalid, pat[c-1] == 1);
         if (m1_gnt) n1++;
         nxt();
      end
      idle_in();

      // Write then read back
      m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hDEADBEEF;
      smp();
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 32'h20);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      nxt();
      m0_we = 0;
      smp();
      chk("rb_mem_re", mem_re, 1);
      nxt(); idle_in();
      smp();
      chk("rb_rvalid", m0_rvalid, 1);
      chk("rb_rdata", m0_rdata, 32'hDEADBEEF);
      nxt();

      // Error accesses: out of range read and misaligned write
      m0_req = 1; m0_addr = 32'h600;
      m1_req = 1; m1_we = 1; m1_addr = 32'h6; m1_wdata = 32'h12345678;
      smp();
      chk("err_gnt1", m1_gnt, 1);
      chk("err_mem_we_a", mem_we, 0);
      chk("err_mem_re_a", mem_re, 0);
      nxt();
      m1_req = 0; m1_we = 0;
      smp();
      chk("err_gnt0", m0_gnt, 1);
      chk("err_mem_we_b", mem_we, 0);
      chk("err_mem_re_b", mem_re, 0);
      chk("err_rv1", m1_rvalid, 1);
      chk("err_err1", m1_err, 1);
      chk("err_rd1", m1_rdata, 0);
      nxt(); idle_in();
      smp();
      chk("err_rv0", m0_rvalid, 1);
      chk("err_err0", m0_err, 1);
      chk("err_rd0", m0_rdata, 0);
      chk("err_mem1_kept", mem[1], 32'h1001);
      nxt();

      // Last implemented word is legal
      m0_req = 1; m0_addr = 32'h5FC;
      smp();
      chk("top_mem_re", mem_re, 1);
      nxt(); idle_in();
      smp();
      chk("top_err", m0_err, 0);
      chk("top_rdata", m0_rdata, 32'h117F);
      nxt();

      // Reset in the third cycle of a port 1 locked burst
      m1_req = 1; m1_lock = 1; m1_addr = 32'h40;
      smp();
      chk("rb1_gnt1", m1_gnt, 1);
      nxt();
      m1_addr = 32'h44; m0_req = 1; m0_addr = 32'h48;
      smp();
      chk("rb2_gnt1", m1_gnt, 1);
      chk("rb2_gnt0", m0_gnt, 0);
      nxt();
      m1_addr = 32'h4C; reset = 1;
      smp();
      chk("rb3_gnt1", m1_gnt, 0);
      chk("rb3_gnt0", m0_gnt, 0);
      chk("rb3_mem_re", mem_re, 0);
      nxt();
      reset = 0;
      smp();
      chk("rb4_rv1", m1_rvalid, 0);
      chk("rb4_gnt0", m0_gnt, 1);
      chk("rb4_gnt1", m1_gnt, 0);
      nxt();
      m0_req = 0;
      smp();
      chk("rb5_gnt1", m1_gnt, 1);
      chk("rb5_rv0", m0_rvalid, 1);
      nxt(); idle_in();
      smp();
      chk("rb6_rv1", m1_rvalid, 1);
      chk("rb6_rd1", m1_rdata, 32'h1013);
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
